matrix_frame_scheduler: RTL and testbench

MATRIX_FRAME_SCHEDULER -- requirements
Module: matrix_frame_scheduler

---
 rtl/matrix_frame_scheduler_pkg.sv | 21 ++
 rtl/matrix_frame_scheduler_arb.sv | 32 +++
 rtl/matrix_frame_scheduler.sv | 114 +++++++++++
 tb/tb_matrix_frame_scheduler.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_frame_scheduler_pkg.sv
// Shared render package for the matrix frame scheduler.
// Holds matrix geometry, FSM state codes and matrix-state codes.
package matrix_frame_scheduler_pkg;

    // 4x4 matrix of 21-bit Q-format entries, packed
    localparam int MTX_W = 336;
    localparam int ST_W  = 4;

    // Scheduler FSM states
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PEND   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;
    localparam logic [1:0] S_NORM   = 2'd3;

    // Matrix-state codes carried alongside each matrix
    localparam logic [3:0] MST_NONE   = 4'h0;
    localparam logic [3:0] MST_VALID  = 4'h1;
    localparam logic [3:0] MST_IDENT  = 4'h2;
    localparam logic [3:0] MST_SCALED = 4'h3;

endpackage

// File: rtl/matrix_frame_scheduler_arb.sv
// Two-way round-robin arbiter with a last-grant pointer.
// Ports: clk, rst_n, req[1:0], en in; grant[1:0] one-hot out.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant
);

    // 1 after reset so requester 0 wins the first tie
    logic last;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (req == 2'b11)
                grant = last ? 2'b01 : 2'b10;
            else
                grant = req;
        end
    end

    // A grant is always a transfer: grant only goes to a valid requester
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last <= 1'b1;
        else if (en && (req != 2'b00))
            last <= grant[1];
    end

endmodule

// File: rtl/matrix_frame_scheduler.sv
// Accepts matrices from two requesters, commits at vertical blank and
// supervises normalization. Ports: CLK, rst_n, req0/1 handshake,
// frame_start, norm_start/norm_done, mtrxOut, matrixStateOut, busy,
// err_timeout.
module matrix_frame_scheduler
    import matrix_frame_scheduler_pkg::*;
#(
    parameter int MTX_W   = matrix_frame_scheduler_pkg::MTX_W,
    parameter int ST_W    = matrix_frame_scheduler_pkg::ST_W,
    parameter int TIMEOUT = 64
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [MTX_W-1:0] req0_mtx,
    input  logic [ST_W-1:0]  req0_state,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [MTX_W-1:0] req1_mtx,
    input  logic [ST_W-1:0]  req1_state,
    output logic             req1_ready,
    input  logic             frame_start,
    output logic             norm_start,
    input  logic             norm_done,
    output logic [MTX_W-1:0] mtrxOut,
    output logic [ST_W-1:0]  matrixStateOut,
    output logic             busy,
    output logic             err_timeout
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [1:0]       grant;
    logic             xfer;
    logic             commit;
    logic             tmo;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic [MTX_W-1:0] stg_mtx;
    logic [ST_W-1:0]  stg_st;

    // Gating with rst_n keeps ready low while reset is held
    rr_arbiter2 u_arb (
        .clk   (CLK),
        .rst_n (rst_n),
        .req   ({req1_valid, req0_valid}),
        .en    ((state == S_IDLE) && rst_n),
        .grant (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign xfer       = |grant;
    assign commit     = (state == S_PEND) && frame_start;
    assign cnt_nxt    = cnt + CW'(1);

    always_comb begin
        state_nxt = state;
        tmo       = 1'b0;
        case (state)
            S_IDLE:   if (xfer) state_nxt = S_PEND;
            S_PEND:   if (frame_start) state_nxt = S_COMMIT;
            S_COMMIT: state_nxt = S_NORM;
            S_NORM: begin
                if (norm_done) begin
                    state_nxt = S_IDLE;
                end else if (cnt_nxt == TMO) begin
                    tmo       = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            busy           <= 1'b0;
            norm_start     <= 1'b0;
            err_timeout    <= 1'b0;
            cnt            <= '0;
            stg_mtx        <= '0;
            stg_st         <= '0;
            mtrxOut        <= '0;
            matrixStateOut <= '0;
        end else begin
            state      <= state_nxt;
            busy       <= (state_nxt != S_IDLE);
            norm_start <= commit;
            if (xfer) begin
                stg_mtx <= grant[1] ? req1_mtx : req0_mtx;
                stg_st  <= grant[1] ? req1_state : req0_state;
            end
            // Outputs update on the commit edge so they appear
            // together with norm_start
            if (commit) begin
                mtrxOut        <= stg_mtx;
                matrixStateOut <= stg_st;
            end
            // First NORM cycle sees a count of 1
            if (state == S_COMMIT)
                cnt <= CW'(1);
            else if ((state == S_NORM) && (cnt != TMO))
                cnt <= cnt_nxt;
            if (tmo)
                err_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_matrix_frame_scheduler.sv
// Self-checking bench for matrix_frame_scheduler.
// Table-driven arbitration/commit vectors plus directed corner cases.
module tb_matrix_frame_scheduler;

    localparam int MTX_W = 336;
    localparam int ST_W  = 4;

    logic             CLK;
    logic             rst_n;
    logic             req0_valid;
    logic [MTX_W-1:0] req0_mtx;
    logic [ST_W-1:0]  req0_state;
    logic             req0_ready;
    logic             req1_valid;
    logic [MTX_W-1:0] req1_mtx;
    logic [ST_W-1:0]  req1_state;
    logic             req1_ready;
    logic             frame_start;
    logic             norm_start;
    logic             norm_done;
    logic [MTX_W-1:0] mtrxOut;
    logic [ST_W-1:0]  matrixStateOut;
    logic             busy;
    logic             err_timeout;

    int errors = 0;
    int checks = 0;

    matrix_frame_scheduler #(
        .MTX_W   (MTX_W),
        .ST_W    (ST_W),
        .TIMEOUT (64)
    ) dut (
        .CLK            (CLK),
        .rst_n          (rst_n),
        .req0_valid     (req0_valid),
        .req0_mtx       (req0_mtx),
        .req0_state     (req0_state),
        .req0_ready     (req0_ready),
        .req1_valid     (req1_valid),
        .req1_mtx       (req1_mtx),
        .req1_state     (req1_state),
        .req1_ready     (req1_ready),
        .frame_start    (frame_start),
        .norm_start     (norm_start),
        .norm_done      (norm_done),
        .mtrxOut        (mtrxOut),
        .matrixStateOut (matrixStateOut),
        .busy           (busy),
        .err_timeout    (err_timeout)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic v0;
        logic v1;
        logic g;
    } vec_t;

    vec_t tbl [8];

    function automatic logic [MTX_W-1:0] mk(input int k);
        logic [20:0] w;
        w = 21'(k * 4951 + 165);
        return {16{w}};
    endfunction

    task automatic chk(input string name,
                       input logic [MTX_W-1:0] act,
                       input logic [MTX_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid  = 1'b0;
        req1_valid  = 1'b0;
        frame_start = 1'b0;
        norm_done   = 1'b0;
    endtask

    // Finish a normalization run with norm_done in the first NORM cycle
    task automatic finish_norm();
        tick();
        norm_done = 1'b1;
        tick();
        norm_done = 1'b0;
        chk("done_busy", busy, 0);
    endtask

    logic [MTX_W-1:0] exp_m;
    logic [ST_W-1:0]  exp_s;
    logic [MTX_W-1:0] last_m;

    initial begin
        tbl[0] = '{1, 1, 0};
        tbl[1] = '{1, 1, 1};
        tbl[2] = '{1, 1, 0};
        tbl[3] = '{1, 0, 0};
        tbl[4] = '{1, 1, 1};
        tbl[5] = '{0, 1, 1};
        tbl[6] = '{1, 1, 0};
        tbl[7] = '{0, 1, 1};

        rst_n      = 1'b0;
        idle_inputs();
        req0_mtx   = mk(100);
        req1_mtx   = mk(101);
        req0_state = 4'h1;
        req1_state = 4'h2;
        req0_valid = 1'b1;
        #3;
        chk("rst_ready0", req0_ready, 0);
        chk("rst_mtx", mtrxOut, 0);
        chk("rst_st", matrixStateOut, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ns", norm_start, 0);
        chk("rst_err", err_timeout, 0);
        req0_valid = 1'b0;
        #9 rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            req0_valid = tbl[i].v0;
            req1_valid = tbl[i].v1;
            req0_mtx   = mk(2 * i);
            req1_mtx   = mk(2 * i + 1);
            exp_m      = mk(2 * i + int'(tbl[i].g));
            exp_s      = tbl[i].g ? 4'h2 : 4'h1;
            #1;
            chk($sformatf("v%0d_rdy0", i), req0_ready, !tbl[i].g);
            chk($sformatf("v%0d_rdy1", i), req1_ready, tbl[i].g);
            tick();
            idle_inputs();
            chk($sformatf("v%0d_busy", i), busy, 1);
            chk($sformatf("v%0d_rdy_pend", i), req0_ready | req1_ready, 0);
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            chk($sformatf("v%0d_mtx", i), mtrxOut, exp_m);
            chk($sformatf("v%0d_st", i), matrixStateOut, exp_s);
            chk($sformatf("v%0d_ns", i), norm_start, 1);
            finish_norm();
            chk($sformatf("v%0d_ns_low", i), norm_start, 0);
        end
        last_m = mk(15);

        // frame_start coincident with the transfer is not a commit
        req0_valid  = 1'b1;
        req0_mtx    = mk(200);
        frame_start = 1'b1;
        #1;
        chk("b_rdy0", req0_ready, 1);
        tick();
        idle_inputs();
        chk("b_hold_mtx", mtrxOut, last_m);
        chk("b_hold_ns", norm_start, 0);
        chk("b_busy", busy, 1);
        tick();
        chk("b_still_pend", norm_start, 0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("b_commit", mtrxOut, mk(200));
        chk("b_ns", norm_start, 1);
        finish_norm();
        last_m = mk(200);

        // norm_done and frame_start while IDLE are ignored
        norm_done = 1'b1;
        tick();
        norm_done = 1'b0;
        chk("idle_done_busy", busy, 0);
        chk("idle_done_err", err_timeout, 0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("idle_fs_busy", busy, 0);
        chk("idle_fs_ns", norm_start, 0);

        // frame_start inside NORM is ignored
        req1_valid = 1'b1;
        req1_mtx   = mk(300);
        tick();
        idle_inputs();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("d_commit", mtrxOut, mk(300));
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("norm_fs_busy", busy, 1);
        chk("norm_fs_ns", norm_start, 0);
        chk("norm_fs_mtx", mtrxOut, mk(300));
        norm_done = 1'b1;
        tick();
        norm_done = 1'b0;
        chk("norm_fs_idle", busy, 0);
        chk("norm_fs_err", err_timeout, 0);
        last_m = mk(300);

        // Normalization timeout
        req0_valid = 1'b1;
        req0_mtx   = mk(400);
        tick();
        idle_inputs();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("t_ns", norm_start, 1);
        for (int c = 1; c < 64; c++) tick();
        chk("t63_err", err_timeout, 0);
        chk("t63_busy", busy, 1);
        tick();
        chk("t64_err", err_timeout, 1);
        chk("t64_busy", busy, 0);
        chk("t64_mtx", mtrxOut, mk(400));
        tick();
        tick();
        chk("t_sticky", err_timeout, 1);

        // Reset while a matrix is staged
        req0_valid = 1'b1;
        req0_mtx   = mk(500);
        tick();
        idle_inputs();
        chk("c_busy", busy, 1);
        rst_n      = 1'b0;
        req0_valid = 1'b1;
        #2;
        chk("c_rst_rdy0", req0_ready, 0);
        chk("c_rst_mtx", mtrxOut, 0);
        chk("c_rst_err", err_timeout, 0);
        req0_valid = 1'b0;
        #2 rst_n   = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("c_no_ns", norm_start, 0);
        chk("c_busy_low", busy, 0);
        chk("c_mtx0", mtrxOut, 0);
        tick();
        chk("c_no_ns2", norm_start, 0);
        req0_valid = 1'b1;
        #1;
        chk("c_rdy0", req0_ready, 1);
        tick();
        idle_inputs();
        chk("c_rearm_busy", busy, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
